fpu_rr_arbiter: RTL
===================

# fpu_rr_arbiter

Shares one multi-cycle FPU between `N_REQ` requesters. Each requester presents an operand pair. The arbiter grants the FPU round-robin, issues a one-cycle start, waits for the FPU done pulse (bounded by a watchdog) and returns the result to the granted requester over a valid/ready response channel. It sits between the requesters and the FPU core, and it is the only block that drives FPU operands.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; 2..8.
- `TIMEOUT`, default 64: maximum cycles in WAIT before abort; ≥ 2.

Ports:
- `clock_100Khz`  in  1: the single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-low. It is sampled on the rising edge of `clock_100Khz`, and there is no asynchronous path.
- `req_valid`  in  N_REQ: requester i has an operand pair pending.
- `req_op_a`  in  32*N_REQ: operand A, slice [32i+31:32i] for requester i.
- `req_op_b`  in  32*N_REQ: operand B, same slicing as `req_op_a`.
- `req_ready`  out  N_REQ: one-hot accept pulse.
- `rsp_valid`  out  N_REQ: one-hot; the response for requester i is valid.
- `rsp_ready`  in  N_REQ: requester i consumes the response.
- `rsp_data`  out  32: result word, shared by all requesters.
- `rsp_status`  out  4: status code. 0 = OVERFLOW, 1 = UNDERFLOW, 2 = EXACT, 3 = INEXACT.
- `rsp_timeout`  out  1: set when the response was aborted by the watchdog.
- `fpu_start`  out  1: one-cycle start pulse to the FPU.
- `fpu_op_a`  out  32: operand A to the FPU, held stable from ISSUE through WAIT.
- `fpu_op_b`  out  32: operand B to the FPU, held stable from ISSUE through WAIT.
- `fpu_done`  in  1: FPU result valid pulse.
- `fpu_result`  in  32: FPU result word.
- `fpu_status`  in  4: FPU status, same encoding as `rsp_status`.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any `req_valid` bit is set, grant `g` = the first set index at or after `ptr`, searching upward and wrapping modulo `N_REQ`.
  - Assert `req_ready[g]` in that same cycle (a combinational function of state, `req_valid` and `ptr`).
  - Latch slice g of `req_op_a`/`req_op_b` into the operand registers and latch `g`, then go to ISSUE.
- ISSUE: `fpu_start`=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - If `fpu_done`=1, latch `fpu_result` and `fpu_status` into `rsp_data`/`rsp_status`, clear `rsp_timeout`, and go to RESPOND.
  - Otherwise, if the counter equals `TIMEOUT-1`, set `rsp_data`=0, `rsp_status`=0 (OVERFLOW) and `rsp_timeout`=1, then go to RESPOND.
  - Otherwise increment the counter.
  - The counter has width $clog2(TIMEOUT) and does not wrap.
- RESPOND:
  - `rsp_valid[g]`=1, with `rsp_data`, `rsp_status` and `rsp_timeout` held stable.
  - On `rsp_ready[g]`=1, set `ptr` ← (g+1) mod `N_REQ` and go to IDLE.
  - `rsp_ready` bits for other indices are ignored.
- `fpu_done` is ignored outside WAIT, including a late done after a timeout.
- `req_ready` is 0 in all states other than IDLE. A requester must hold `req_valid` and its operands until it sees `req_ready`.
- `fpu_op_a`/`fpu_op_b` come from the operand registers, which change only on an IDLE accept.
- Only one transaction is in flight at a time; there is no queuing.

## Timing

- Reset values: state=IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=2 (EXACT), `rsp_timeout`=0, `fpu_start`=0, `fpu_op_a`=0, `fpu_op_b`=0, watchdog counter=0.
- Latency for an accept in cycle T:
  - `fpu_start` is high in cycle T+1.
  - With `fpu_done` first sampled high in cycle T+1+k (k ≥ 1), `rsp_valid` rises in cycle T+2+k.
- Timeout: with no `fpu_done`, `rsp_valid` rises in cycle T+2+TIMEOUT.
- Minimum spacing between accepts is 4 cycles, reached when the response is consumed immediately.
- Back-to-back operation: after `rsp_ready` in cycle R, the next accept can occur in cycle R+1.
- A `fpu_done` in the same cycle as `fpu_start` is not possible, because the ISSUE state does not sample done.
- Reset low in any state (including mid-WAIT):
  - Return to reset values on the next edge.
  - The pending transaction is dropped with no response.
  - The FPU is not otherwise notified.
- Simultaneous requests are served in `ptr` order. No requester waits more than `N_REQ`-1 grants while its `req_valid` is held.

## Test plan

- Single request:
  - Stimulus: req 0 with A=0x3F800000, B=0x40000000; model FPU pulses done 7 cycles after start with result 0x40400000, status 2.
  - Required response: `fpu_start` at T+1; `rsp_valid[0]` at T+9 with data 0x40400000, status 2, `rsp_timeout`=0.
- Fairness:
  - Stimulus: all four `req_valid` held high from reset; `rsp_ready` tied high.
  - Required response: grant order 0,1,2,3,0; each accept exactly 4 cycles apart when done has k=1.
- Watchdog:
  - Stimulus: request 2; the FPU never asserts done.
  - Required response: `rsp_valid[2]` at T+2+64 with data 0, status 0, `rsp_timeout`=1.
  - A late `fpu_done` arriving in RESPOND or IDLE leaves the outputs unchanged.
- Response backpressure:
  - Stimulus: hold `rsp_ready[1]`=0 for 10 cycles.
  - Required response: `rsp_valid[1]` stays high with stable data; `req_ready` stays 0 despite pending `req_valid[3]`; `req_valid[3]` is accepted 1 cycle after `rsp_ready[1]`.
- Reset mid-WAIT:
  - Stimulus: drive reset low for 1 cycle 3 cycles after start.
  - Required response: all outputs return to reset values; no `rsp_valid` appears; the next accept grants the lowest pending index starting from 0.
- Stray done:
  - Stimulus: pulse `fpu_done` in IDLE with result 0xDEADBEEF.
  - Required response: `rsp_data` stays unchanged, and no `rsp_valid` is asserted.

Source files
------------

// File: rtl/fpu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_rr_arbiter
//
// Purpose:
//   Shares one multi-cycle FPU between N_REQ requesters. A requester is
//   granted round-robin, its operand pair is captured and presented to the FPU,
//   a one-cycle start is issued, and the FPU result (or a watchdog abort) is
//   returned to that requester over a valid/ready response channel. Only one
//   transaction is in flight at a time.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  maximum cycles spent waiting for fpu_done before abort (>= 2)
//
// Ports:
//   clock_100Khz  in   rising-edge clock for all logic
//   reset         in   synchronous, active-low reset
//   req_valid     in   [N_REQ]     requester i has an operand pair pending
//   req_op_a      in   [32*N_REQ]  operand A, slice [32i+31:32i]
//   req_op_b      in   [32*N_REQ]  operand B, same slicing
//   req_ready     out  [N_REQ]     one-hot accept pulse (IDLE only)
//   rsp_valid     out  [N_REQ]     one-hot response valid
//   rsp_ready     in   [N_REQ]     requester consumes the response
//   rsp_data      out  [32]        result word shared by all requesters
//   rsp_status    out  [4]         0=OVERFLOW 1=UNDERFLOW 2=EXACT 3=INEXACT
//   rsp_timeout   out  1           response was aborted by the watchdog
//   fpu_start     out  1           one-cycle start pulse to the FPU
//   fpu_op_a      out  [32]        operand A to the FPU
//   fpu_op_b      out  [32]        operand B to the FPU
//   fpu_done      in   1           FPU result valid pulse
//   fpu_result    in   [32]        FPU result word
//   fpu_status    in   [4]         FPU status code
// -----------------------------------------------------------------------------
module fpu_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock_100Khz,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_op_a,
    input  logic [32*N_REQ-1:0]   req_op_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [3:0]            rsp_status,
    output logic                  rsp_timeout,
    output logic                  fpu_start,
    output logic [31:0]           fpu_op_a,
    output logic [31:0]           fpu_op_b,
    input  logic                  fpu_done,
    input  logic [31:0]           fpu_result,
    input  logic [3:0]            fpu_status
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       ST_OVERFLOW = 4'd0;
    localparam logic [3:0]       ST_EXACT    = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic [CNT_W-1:0] wd_cnt;

    logic             grant_found;
    logic [PTR_W-1:0] grant_sel;
    logic [31:0]      sel_op_a;
    logic [31:0]      sel_op_b;

    // Round-robin pick: scan offsets from the highest down so that the
    // smallest offset from ptr (the first hit searching upward) wins.
    always_comb begin
        int idx;
        int gidx;
        grant_found = 1'b0;
        grant_sel   = '0;
        idx         = 0;
        gidx        = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                gidx        = idx;
            end
        end
        grant_sel = PTR_W'(gidx);
        sel_op_a  = req_op_a[32*gidx +: 32];
        sel_op_b  = req_op_b[32*gidx +: 32];
    end

    // Next-state and handshake outputs. The response is only closed by the
    // ready bit of the granted requester; other ready bits are don't-care.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        fpu_start  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_sel] = 1'b1;
                    state_next           = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (fpu_done || (wd_cnt == WD_LAST)) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus datapath. fpu_done is only looked at in WAIT, so a
    // stray or late done pulse can never disturb the response registers.
    always_ff @(posedge clock_100Khz) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            wd_cnt      <= '0;
            rsp_data    <= '0;
            rsp_status  <= ST_EXACT;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_q <= grant_sel;
                        op_a_q  <= sel_op_a;
                        op_b_q  <= sel_op_b;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (fpu_done) begin
                        rsp_data    <= fpu_result;
                        rsp_status  <= fpu_status;
                        rsp_timeout <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_data    <= '0;
                        rsp_status  <= ST_OVERFLOW;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    if (rsp_ready[grant_q]) begin
                        ptr <= (grant_q == LAST_IDX) ? '0 : grant_q + PTR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fpu_op_a = op_a_q;
    assign fpu_op_b = op_b_q;

endmodule
